pingpong_frame_buffer: RTL and testbench
========================================

Name: pingpong_frame_buffer

Overview:
Parametrised ping-pong group buffer between the serial word receiver and the frame former. Received words fill one bank while the frame former reads the other. Banks swap on completion handshakes. Adds frame resync, overflow accounting and configurable width/depth, none of which the current fixed 12-bit/1024-word pair has. Single clock domain; any CDC to the frame-former clock is handled outside this block.

Parameters:
IN_W, 16, width of incoming receiver word
DATA_W, 12, stored/read word width; the DATA_W LSBs of in_word are stored
ADDR_W, 10, bank address width
DEPTH, 1024, words per bank; 2 <= DEPTH <= 2**ADDR_W
OVF_W, 16, overflow counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_word  in  IN_W  received word
in_valid  in  1  one-cycle strobe, in_word valid
in_sync  in  1  frame marker; restarts the current fill at address 0
rd_en  in  1  read strobe from the frame former
rd_addr  in  ADDR_W  read address within the active read bank
rd_done  in  1  one-cycle pulse: reader has finished the active bank
rd_data  out  DATA_W  registered read data
rd_bank  out  1  index of the bank being read (frame-former switch)
rd_ready  out  1  active read bank holds a complete group
wr_bank  out  1  index of the bank being filled
ovf_cnt  out  OVF_W  saturating count of dropped words
ovf  out  1  sticky; set on the first drop, cleared only by reset

Behaviour:
- Reset (async, reset=0):
  - Outputs: rd_data=0, rd_bank=0, rd_ready=0, wr_bank=0, ovf_cnt=0, ovf=0.
  - Internal: both banks EMPTY, wr_addr=0, write FSM=FILL.
  - RAM contents are not cleared.
- Bank status per bank: EMPTY, FILLING, FULL, READING.
- Write FSM:
  - FILL: each in_valid writes in_word[DATA_W-1:0] to wr_bank at wr_addr, and wr_addr increments.
  - FILL, write at wr_addr=DEPTH-1: the bank becomes FULL and wr_addr wraps to 0. If the other bank is EMPTY, wr_bank toggles next cycle and the FSM stays in FILL; otherwise it goes to WAIT.
  - WAIT: every in_valid is dropped (ovf_cnt+1, saturating at all-ones; ovf<=1). When the other bank becomes EMPTY, wr_bank toggles and the FSM returns to FILL the following cycle. A word arriving in the same cycle as the freeing rd_done is dropped.
- in_sync:
  - In FILL, in_sync sets wr_addr=0 and discards the partial group.
  - in_sync together with in_valid: the word is written at address 0 and wr_addr becomes 1.
  - in_sync in WAIT is ignored.
- Read side:
  - Read bank promotion: when rd_ready=0 and the bank at rd_bank is FULL, that bank becomes READING and rd_ready=1 next cycle.
  - rd_en with rd_ready=1: rd_data = bank[rd_bank][rd_addr], one-cycle latency.
  - rd_en with rd_ready=0: ignored; rd_data holds.
- rd_done:
  - With rd_ready=1: the READING bank becomes EMPTY and rd_bank toggles next cycle. rd_ready=1 continues if the new bank is already FULL (promoted in the same cycle); otherwise rd_ready=0.
  - With rd_ready=0: ignored.
- Simultaneous events:
  - rd_done and final write of the other bank in one cycle: the written bank becomes FULL, the read bank becomes EMPTY. Next cycle rd_bank = former wr_bank with rd_ready=1, and wr_bank toggles into the freed bank in FILL; no word is lost.
  - Read and write never target the same bank, by construction.
- Reset mid-operation: all status returns to the reset values; partial groups are lost; the bench must not rely on RAM contents.

Decomposition:
- Shared package pp_buf_pkg:
  - bank status enum (EMPTY/FILLING/FULL/READING);
  - write FSM enum (FILL/WAIT);
  - default width constants.
- Sub-module pp_bank_ram: simple dual-port RAM (DEPTH x DATA_W, registered read, rden gating), instantiated twice.
- Top: write/read control FSMs and counters.

Test Plan:
Use DEPTH=8, ADDR_W=3, DATA_W=12, IN_W=16.
- Basic fill: 8 in_valid words 0x1001..0x1008 -> rd_ready=1, rd_bank=0, wr_bank=1. Reads addr 0..7 return 0x001..0x008, each one cycle after rd_en.
- Ping-pong: read bank 0 while writing 8 words to bank 1, then rd_done -> rd_bank=1, rd_ready stays 1, wr_bank=0, ovf_cnt=0.
- Overflow: 16 words without rd_done, then 3 more -> write FSM in WAIT, ovf_cnt=3, ovf=1. rd_done then frees bank 0 and the next word lands at bank 0 addr 0.
- Resync: 5 words, in_sync with word 0xABC, 7 more words -> bank 0 reads 0xABC at addr 0 followed by the 7 new words; the first 5 words are absent.
- Simultaneous: rd_done in the same cycle as the 8th write to bank 1 -> next cycle rd_bank=1, rd_ready=1, wr_bank=0, no drop counted.
- Async reset asserted mid-fill (addr 4) and mid-read -> all outputs are 0 immediately, with no clock edge needed. After release, the first 8 words fill bank 0 from addr 0.

Source files
------------

// File: rtl/pp_buf_pkg.sv
// Shared types and default sizes for the ping-pong frame buffer.
// Bank status and write-side FSM encodings live here so both RTL files agree on them.
package pp_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;

  typedef enum logic {
    WR_FILL,
    WR_WAIT
  } wr_state_t;

  localparam int PP_IN_W   = 16;
  localparam int PP_DATA_W = 12;
  localparam int PP_ADDR_W = 10;
  localparam int PP_DEPTH  = 1024;
  localparam int PP_OVF_W  = 16;

endpackage

// File: rtl/pp_bank_ram.sv
// One bank of the ping-pong pair: simple dual-port RAM with a gated, registered read.
// Only the read register is reset so the array itself still maps onto block RAM.
module pp_bank_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Ping-pong group buffer: receiver words fill one bank while the frame former reads the other.
// Banks swap on group completion and rd_done; words arriving with no free bank are counted as drops.
module pingpong_frame_buffer
  import pp_buf_pkg::*;
#(
  parameter int IN_W   = PP_IN_W,
  parameter int DATA_W = PP_DATA_W,
  parameter int ADDR_W = PP_ADDR_W,
  parameter int DEPTH  = PP_DEPTH,
  parameter int OVF_W  = PP_OVF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   in_word,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_bank,
  output logic              rd_ready,
  output logic              wr_bank,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              ovf
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bank_state_t       bank_state [2];
  wr_state_t         wr_state;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_sel;
  logic [DATA_W-1:0] ram_q [2];

  logic              wr_fire;
  logic              wr_last;
  logic [ADDR_W-1:0] wr_ptr;
  logic              rd_fire;
  logic              rd_release;
  logic              other_free;
  logic              next_full;
  logic              drop;

  assign wr_fire    = (wr_state == WR_FILL) && in_valid;
  assign wr_ptr     = in_sync ? '0 : wr_addr;
  assign wr_last    = wr_fire && (wr_ptr == LAST_ADDR);
  assign rd_fire    = rd_en && rd_ready;
  assign rd_release = rd_done && rd_ready;
  assign drop       = (wr_state == WR_WAIT) && in_valid;

  // A bank freed by rd_done this cycle counts as free, so a simultaneous final write loses nothing.
  assign other_free = (bank_state[~wr_bank] == BANK_EMPTY) ||
                      (rd_release && (rd_bank != wr_bank));
  assign next_full  = (bank_state[~rd_bank] == BANK_FULL) ||
                      (wr_last && (wr_bank != rd_bank));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      pp_bank_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
      ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_fire && (wr_bank == 1'(gi))),
        .wr_addr(wr_ptr),
        .wr_data(in_word[DATA_W-1:0]),
        .rd_en  (rd_fire && (rd_bank == 1'(gi))),
        .rd_addr(rd_addr),
        .rd_data(ram_q[gi])
      );
    end

    if (IN_W > DATA_W) begin : g_unused_msbs
      logic unused_in_msbs;
      assign unused_in_msbs = ^in_word[IN_W-1:DATA_W];
    end
  endgenerate

  // rd_sel follows the bank of the last accepted read, so rd_data holds across ignored reads and swaps.
  assign rd_data = ram_q[rd_sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      wr_state      <= WR_FILL;
      wr_addr       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_ready      <= 1'b0;
      rd_sel        <= 1'b0;
      ovf_cnt       <= '0;
      ovf           <= 1'b0;
    end else begin
      if (rd_fire) rd_sel <= rd_bank;

      case (wr_state)
        WR_FILL: begin
          if (wr_fire) begin
            if (wr_last) begin
              bank_state[wr_bank] <= BANK_FULL;
              wr_addr             <= '0;
              if (other_free) wr_bank  <= ~wr_bank;
              else            wr_state <= WR_WAIT;
            end else begin
              bank_state[wr_bank] <= BANK_FILLING;
              wr_addr             <= wr_ptr + 1'b1;
            end
          end else if (in_sync) begin
            wr_addr <= '0;
          end
        end
        WR_WAIT: begin
          if (other_free) begin
            wr_bank  <= ~wr_bank;
            wr_state <= WR_FILL;
          end
          if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
          end
        end
        default: wr_state <= WR_FILL;
      endcase

      // Read-side updates come last so a same-cycle promotion overrides the FULL set above.
      if (rd_release) begin
        bank_state[rd_bank] <= BANK_EMPTY;
        rd_bank             <= ~rd_bank;
        if (next_full) begin
          bank_state[~rd_bank] <= BANK_READING;
          rd_ready             <= 1'b1;
        end else begin
          rd_ready <= 1'b0;
        end
      end else if (!rd_ready && (bank_state[rd_bank] == BANK_FULL)) begin
        bank_state[rd_bank] <= BANK_READING;
        rd_ready            <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer (DEPTH=8); read data is checked against a queue
// of expected words pushed when each read strobe is driven.
module tb_pingpong_frame_buffer;

  localparam int IN_W   = 16;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int OVF_W  = 16;

  logic              clk;
  logic              reset;
  logic [IN_W-1:0]   in_word;
  logic              in_valid;
  logic              in_sync;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_bank;
  logic              rd_ready;
  logic              wr_bank;
  logic [OVF_W-1:0]  ovf_cnt;
  logic              ovf;

  int compared   = 0;
  int mismatched = 0;
  logic [DATA_W-1:0] sb [$];

  pingpong_frame_buffer #(
    .IN_W  (IN_W),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .OVF_W (OVF_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_word (in_word),
    .in_valid(in_valid),
    .in_sync (in_sync),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_done (rd_done),
    .rd_data (rd_data),
    .rd_bank (rd_bank),
    .rd_ready(rd_ready),
    .wr_bank (wr_bank),
    .ovf_cnt (ovf_cnt),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [IN_W-1:0] w, input logic s);
    in_word  = w;
    in_sync  = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    sb.push_back(e);
    step();
    rd_en = 1'b0;
    chk($sformatf("rd_data addr%0d", a), 32'(rd_data), 32'(sb.pop_front()));
  endtask

  task automatic done_pulse();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    for (int n = 0; n < budget && !rd_ready; n++) step();
    chk("rd_ready wait", 32'(rd_ready), 32'd1);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #2;
    chk({tag, " rd_data"},  32'(rd_data),  32'd0);
    chk({tag, " rd_bank"},  32'(rd_bank),  32'd0);
    chk({tag, " rd_ready"}, 32'(rd_ready), 32'd0);
    chk({tag, " wr_bank"},  32'(wr_bank),  32'd0);
    chk({tag, " ovf_cnt"},  32'(ovf_cnt),  32'd0);
    chk({tag, " ovf"},      32'(ovf),      32'd0);
    step();
    reset = 1'b1;
    step();
    $display("txn reset %s", tag);
  endtask

  initial begin
    reset    = 1'b1;
    in_word  = '0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    rd_done  = 1'b0;
    #2;
    async_reset("init");

    // Basic fill of bank 0
    for (int i = 0; i < 8; i++) put(16'h1001 + 16'(i), 1'b0);
    $display("txn basic fill 8 words");
    wait_ready(4);
    chk("basic rd_bank", 32'(rd_bank), 32'd0);
    chk("basic wr_bank", 32'(wr_bank), 32'd1);
    for (int i = 0; i < 8; i++) rd(3'(i), 12'h001 + 12'(i));
    step();
    chk("basic hold", 32'(rd_data), 32'h008);

    // Ping-pong: read bank 0 backwards while bank 1 fills
    for (int i = 0; i < 8; i++) begin
      in_word  = 16'h2101 + 16'(i);
      in_valid = 1'b1;
      rd_en    = 1'b1;
      rd_addr  = 3'(7 - i);
      sb.push_back(12'h008 - 12'(i));
      step();
      in_valid = 1'b0;
      rd_en    = 1'b0;
      chk($sformatf("pp rd_data addr%0d", 7 - i), 32'(rd_data), 32'(sb.pop_front()));
    end
    chk("pp wr_bank held", 32'(wr_bank), 32'd1);
    done_pulse();
    $display("txn ping-pong rd_done");
    chk("pp rd_bank",  32'(rd_bank),  32'd1);
    chk("pp rd_ready", 32'(rd_ready), 32'd1);
    chk("pp wr_bank",  32'(wr_bank),  32'd0);
    chk("pp ovf_cnt",  32'(ovf_cnt),  32'd0);
    for (int i = 0; i < 8; i++) rd(3'(i), 12'h101 + 12'(i));

    // Simultaneous rd_done with the final write of the other bank
    for (int i = 0; i < 7; i++) put(16'h4201 + 16'(i), 1'b0);
    in_word  = 16'h4208;
    in_valid = 1'b1;
    rd_done  = 1'b1;
    step();
    in_valid = 1'b0;
    rd_done  = 1'b0;
    $display("txn simultaneous done+last write");
    chk("sim rd_bank",  32'(rd_bank),  32'd0);
    chk("sim rd_ready", 32'(rd_ready), 32'd1);
    chk("sim wr_bank",  32'(wr_bank),  32'd1);
    chk("sim ovf_cnt",  32'(ovf_cnt),  32'd0);
    chk("sim ovf",      32'(ovf),      32'd0);
    rd(3'd0, 12'h201);
    rd(3'd7, 12'h208);
    put(16'h5555, 1'b0);
    chk("sim no drop", 32'(ovf_cnt), 32'd0);
    done_pulse();
    chk("partial rd_ready", 32'(rd_ready), 32'd0);
    chk("partial rd_bank",  32'(rd_bank),  32'd1);
    rd_en   = 1'b1;
    rd_addr = 3'd0;
    step();
    rd_en = 1'b0;
    chk("ignored read holds", 32'(rd_data), 32'h208);

    // Reset in the middle of a fill (wr_addr=4)
    for (int i = 0; i < 3; i++) put(16'h5556 + 16'(i), 1'b0);
    async_reset("mid-fill");
    for (int i = 0; i < 8; i++) put(16'h6A01 + 16'(i), 1'b0);
    wait_ready(4);
    chk("refill rd_bank", 32'(rd_bank), 32'd0);
    rd(3'd0, 12'hA01);
    rd(3'd4, 12'hA05);

    // Overflow: 16 words fill both banks, 3 more are dropped
    async_reset("pre-ovf");
    for (int i = 0; i < 16; i++) put(16'h7001 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) put(16'h7F01 + 16'(i), 1'b0);
    $display("txn overflow 19 words");
    chk("ovf ovf_cnt",  32'(ovf_cnt),  32'd3);
    chk("ovf flag",     32'(ovf),      32'd1);
    chk("ovf wr_bank",  32'(wr_bank),  32'd1);
    chk("ovf rd_bank",  32'(rd_bank),  32'd0);
    done_pulse();
    chk("ovf free rd_bank",  32'(rd_bank),  32'd1);
    chk("ovf free rd_ready", 32'(rd_ready), 32'd1);
    chk("ovf free wr_bank",  32'(wr_bank),  32'd0);
    rd(3'd0, 12'h009);
    rd(3'd7, 12'h010);
    put(16'h7ABC, 1'b0);
    for (int i = 0; i < 7; i++) put(16'h7B01 + 16'(i), 1'b0);
    done_pulse();
    chk("ovf swap rd_bank",  32'(rd_bank),  32'd0);
    chk("ovf swap rd_ready", 32'(rd_ready), 32'd1);
    chk("ovf swap wr_bank",  32'(wr_bank),  32'd1);
    rd(3'd0, 12'hABC);
    rd(3'd1, 12'hB01);
    chk("ovf_cnt kept", 32'(ovf_cnt), 32'd3);

    // Reset while a bank is being read and ovf is set
    async_reset("mid-read");

    // Resync: 5 words, then sync with 0xABC, then 7 words
    for (int i = 0; i < 5; i++) put(16'h8001 + 16'(i), 1'b0);
    put(16'h8ABC, 1'b1);
    for (int i = 0; i < 7; i++) put(16'h8101 + 16'(i), 1'b0);
    $display("txn resync group");
    wait_ready(4);
    chk("sync rd_bank", 32'(rd_bank), 32'd0);
    rd(3'd0, 12'hABC);
    for (int i = 1; i < 8; i++) rd(3'(i), 12'h100 + 12'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
